// File: rtl/div_hilo_unit_pkg.sv
// Shared types and constants for the HI/LO divide front-end.
//   i32/i64        : 32- and 64-bit data words
//   muldiv_op_t    : operation codes presented by execute
//   div_state_t    : front-end control state
//   DIV0_LO        : LO value written on divide-by-zero
//   mag32()        : two's-complement magnitude (INT_MIN maps to itself)
package div_hilo_unit_pkg;

    typedef logic [31:0] i32;
    typedef logic [63:0] i64;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_DIV  = 3'd1,
        OP_DIVU = 3'd2,
        OP_MTHI = 3'd3,
        OP_MTLO = 3'd4
    } muldiv_op_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } div_state_t;

    localparam i32 DIV0_LO = 32'hFFFF_FFFF;

    // Quotient bits produced by the iterative divider, one per cycle.
    localparam int unsigned DivCycles = 32;

    function automatic i32 mag32(input i32 x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/div_hilo_unit_div.sv
// Unsigned 32/32 restoring divider, one quotient bit per cycle.
//   clk, resetn : clock, synchronous active-low reset
//   valid_i     : start request (sampled while idle)
//   a_i, b_i    : dividend / divisor (b_i must be non-zero)
//   done_o      : high while idle with no request, and in the result cycle
//   c_o         : {remainder, quotient}, valid while done_o is high after a run
module div_hilo_unit_div
    import div_hilo_unit_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic valid_i,
    input  i32   a_i,
    input  i32   b_i,
    output logic done_o,
    output i64   c_o
);

    logic       busy_q, busy_d;
    logic [5:0] cnt_q, cnt_d;
    i32         rem_q, rem_d;
    i32         quo_q, quo_d;
    i32         b_q, b_d;

    logic [32:0] trial;
    logic        ge;
    i32          diff;

    assign trial = {rem_q, quo_q[31]};
    assign ge    = trial >= {1'b0, b_q};
    // When ge holds the difference is below b_q, so 32 bits suffice.
    assign diff  = trial[31:0] - b_q;

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        b_d    = b_q;
        if (!busy_q) begin
            if (valid_i) begin
                busy_d = 1'b1;
                cnt_d  = 6'd0;
                rem_d  = '0;
                quo_d  = a_i;
                b_d    = b_i;
            end
        end else if (cnt_q != 6'(DivCycles)) begin
            rem_d = ge ? diff : trial[31:0];
            quo_d = {quo_q[30:0], ge};
            cnt_d = cnt_q + 6'd1;
        end else begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            b_q    <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            b_q    <= b_d;
        end
    end

    // Masking with ~valid_i keeps done low in the first valid cycle.
    assign done_o = busy_q ? (cnt_q == 6'(DivCycles)) : ~valid_i;
    assign c_o    = {rem_q, quo_q};

endmodule

// File: rtl/div_hilo_unit.sv
// Divide front-end owning the architectural HI/LO registers.
//   clk, resetn    : clock, synchronous active-low reset
//   req_valid_i    : request present this cycle
//   req_op_i       : DIV / DIVU / MTHI / MTLO / NONE
//   req_a_i        : rs (dividend or MTHI/MTLO source)
//   req_b_i        : rt (divisor)
//   flush_i        : kill in-flight or same-cycle request
//   busy_o         : high while a divide runs or is being drained
//   hi_o, lo_o     : HI (remainder) and LO (quotient)
module div_hilo_unit
    import div_hilo_unit_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       req_valid_i,
    input  muldiv_op_t req_op_i,
    input  i32         req_a_i,
    input  i32         req_b_i,
    input  logic       flush_i,
    output logic       busy_o,
    output i32         hi_o,
    output i32         lo_o
);

    div_state_t state_q, state_d;
    i32         a_q, a_d;
    i32         b_q, b_d;
    logic       neg_quo_q, neg_quo_d;
    logic       neg_rem_q, neg_rem_d;
    i32         hi_q, hi_d;
    i32         lo_q, lo_d;

    logic div_valid;
    logic div_done;
    i64   div_c;
    i32   quo_fix;
    i32   rem_fix;

    div_hilo_unit_div u_div (
        .clk     (clk),
        .resetn  (resetn),
        .valid_i (div_valid),
        .a_i     (a_q),
        .b_i     (b_q),
        .done_o  (div_done),
        .c_o     (div_c)
    );

    assign div_valid = (state_q == StRun);
    assign quo_fix   = neg_quo_q ? (~div_c[31:0] + 32'd1) : div_c[31:0];
    assign rem_fix   = neg_rem_q ? (~div_c[63:32] + 32'd1) : div_c[63:32];

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i && !flush_i) begin
                    case (req_op_i)
                        OP_MTHI: hi_d = req_a_i;
                        OP_MTLO: lo_d = req_a_i;
                        OP_DIV, OP_DIVU: begin
                            if (req_b_i == '0) begin
                                hi_d = req_a_i;
                                lo_d = DIV0_LO;
                            end else if (req_op_i == OP_DIV) begin
                                a_d       = mag32(req_a_i);
                                b_d       = mag32(req_b_i);
                                neg_quo_d = req_a_i[31] ^ req_b_i[31];
                                neg_rem_d = req_a_i[31];
                                state_d   = StRun;
                            end else begin
                                a_d       = req_a_i;
                                b_d       = req_b_i;
                                neg_quo_d = 1'b0;
                                neg_rem_d = 1'b0;
                                state_d   = StRun;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            StRun: begin
                if (flush_i) begin
                    state_d = div_done ? StIdle : StDrain;
                end else if (div_done) begin
                    lo_d    = quo_fix;
                    hi_d    = rem_fix;
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (div_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy_o = (state_q != StIdle);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_div_hilo_unit.sv
// Directed self-checking bench for div_hilo_unit.
module tb_div_hilo_unit;
    import div_hilo_unit_pkg::*;

    logic       clk;
    logic       resetn;
    logic       req_valid;
    muldiv_op_t req_op;
    i32         req_a;
    i32         req_b;
    logic       flush;
    logic       busy;
    i32         hi;
    i32         lo;

    int n_cmp = 0;
    int n_err = 0;

    div_hilo_unit dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid_i (req_valid),
        .req_op_i    (req_op),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .flush_i     (flush),
        .busy_o      (busy),
        .hi_o        (hi),
        .lo_o        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for exactly one cycle; returns just after the accepting edge.
    task automatic issue(input muldiv_op_t op, input i32 a, input i32 b);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        tick();
        req_valid = 1'b0;
        req_op    = OP_NONE;
        req_a     = '0;
        req_b     = '0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        if (busy) check({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        resetn    = 1'b0;
        req_valid = 1'b0;
        req_op    = OP_NONE;
        req_a     = '0;
        req_b     = '0;
        flush     = 1'b0;
        tick();
        tick();
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        resetn = 1'b1;
        tick();

        // Signed -7 / 2
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        check("div_neg_busy_t1", {31'b0, busy}, 32'd1);
        tick();
        check("div_neg_busy_t2", {31'b0, busy}, 32'd1);
        wait_idle("div_neg");
        check("div_neg_lo", lo, 32'hFFFF_FFFD);
        check("div_neg_hi", hi, 32'hFFFF_FFFF);

        // Unsigned view of the same bits
        issue(OP_DIVU, 32'hFFFF_FFF9, 32'd2);
        wait_idle("divu");
        check("divu_lo", lo, 32'h7FFF_FFFC);
        check("divu_hi", hi, 32'd1);

        // INT_MIN / -1 wraps
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle("intmin");
        check("intmin_lo", lo, 32'h8000_0000);
        check("intmin_hi", hi, 32'd0);

        // Divide by zero: single cycle, no busy
        issue(OP_DIV, 32'd5, 32'd0);
        check("div0_busy", {31'b0, busy}, 32'd0);
        check("div0_hi", hi, 32'd5);
        check("div0_lo", lo, 32'hFFFF_FFFF);

        // MTHI then MTLO back to back
        issue(OP_MTHI, 32'h1234, 32'd0);
        check("mthi_hi", hi, 32'h1234);
        issue(OP_MTLO, 32'h5678, 32'd0);
        check("mtlo_lo", lo, 32'h5678);
        check("mtlo_hi_kept", hi, 32'h1234);
        check("mt_busy", {31'b0, busy}, 32'd0);

        // Flush together with a request: nothing accepted
        flush = 1'b1;
        issue(OP_MTHI, 32'hDEAD, 32'd0);
        flush = 1'b0;
        check("flush_req_hi", hi, 32'h1234);

        // Flushed divide drains without touching HI/LO
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("drain_busy", {31'b0, busy}, 32'd1);
        tick();
        check("drain_busy2", {31'b0, busy}, 32'd1);
        wait_idle("drain");
        check("drain_hi", hi, 32'h1234);
        check("drain_lo", lo, 32'h5678);

        // Next divide after drain, with a dropped request while busy
        issue(OP_DIV, 32'd100, 32'd7);
        tick();
        issue(OP_DIV, 32'd50, 32'd5);
        check("drop_busy", {31'b0, busy}, 32'd1);
        wait_idle("div100");
        check("div100_lo", lo, 32'd14);
        check("div100_hi", hi, 32'd2);
        tick();
        check("drop_not_started", {31'b0, busy}, 32'd0);

        // Reset mid-run
        issue(OP_DIVU, 32'd1000, 32'd3);
        repeat (3) tick();
        resetn = 1'b0;
        tick();
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        resetn = 1'b1;
        tick();
        issue(OP_DIVU, 32'd9, 32'd3);
        check("post_rst_busy", {31'b0, busy}, 32'd1);
        wait_idle("divu9");
        check("divu9_lo", lo, 32'd3);
        check("divu9_hi", hi, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
